// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, source enum and writeback entry layout
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // Entry layout at the default widths; the FIFOs store rd and data side by side.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - count-based writeback FIFO exposing per-slot valid/rd for hazard compare
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_rd,
  output logic [DATA_W-1:0] head_data,
  output logic [DEPTH-1:0]  ent_valid,
  output logic [ADDR_W-1:0] ent_rd [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rd_mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_mem_d [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [PTR_W-1:0]  offs;
  logic              do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (do_push) begin
      rd_mem_d[wr_ptr_q]   = push_rd;
      data_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    ent_valid = '0;
    offs      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs         = PTR_W'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, offs} < count_q);
      ent_rd[i]    = rd_mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin ALU/load writeback arbiter with pending-write detection
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_writedata,
  output logic              rf_regwrite,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              rs_pending,
  output logic              rt_pending
);

  logic              alu_full, alu_empty, mem_full, mem_empty;
  logic              alu_pop, mem_pop;
  logic [ADDR_W-1:0] alu_head_rd, mem_head_rd, pop_rd;
  logic [DATA_W-1:0] alu_head_data, mem_head_data, pop_data;
  logic [DEPTH-1:0]  alu_ent_valid, mem_ent_valid;
  logic [ADDR_W-1:0] alu_ent_rd [DEPTH];
  logic [ADDR_W-1:0] mem_ent_rd [DEPTH];
  logic              rs_hit, rt_hit;

  src_e              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_writedata_q, rf_writedata_d;
  logic              rf_regwrite_q, rf_regwrite_d;

  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst_n(rst_n), .push(alu_valid && alu_ready), .push_rd(alu_rd),
    .push_data(alu_data), .pop(alu_pop), .full(alu_full), .empty(alu_empty),
    .head_rd(alu_head_rd), .head_data(alu_head_data),
    .ent_valid(alu_ent_valid), .ent_rd(alu_ent_rd)
  );

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_fifo (
    .clk(clk), .rst_n(rst_n), .push(mem_valid && mem_ready), .push_rd(mem_rd),
    .push_data(mem_data), .pop(mem_pop), .full(mem_full), .empty(mem_empty),
    .head_rd(mem_head_rd), .head_data(mem_head_data),
    .ent_valid(mem_ent_valid), .ent_rd(mem_ent_rd)
  );

  always_comb begin
    alu_pop      = 1'b0;
    mem_pop      = 1'b0;
    last_grant_d = last_grant_q;
    if (!alu_empty && !mem_empty) begin
      if (last_grant_q == SRC_ALU) mem_pop = 1'b1;
      else                         alu_pop = 1'b1;
      last_grant_d = (last_grant_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end else if (!alu_empty) begin
      alu_pop = 1'b1;
    end else if (!mem_empty) begin
      mem_pop = 1'b1;
    end
    pop_rd   = mem_pop ? mem_head_rd : alu_head_rd;
    pop_data = mem_pop ? mem_head_data : alu_head_data;
    // Writes to r0 are drained from the queue but never reach the register file.
    rf_regwrite_d  = (alu_pop || mem_pop) && (pop_rd != '0);
    rf_rd_d        = (alu_pop || mem_pop) ? pop_rd : rf_rd_q;
    rf_writedata_d = (alu_pop || mem_pop) ? pop_data : rf_writedata_q;
  end

  always_comb begin
    rs_hit = rf_regwrite_q && (rf_rd_q == rs);
    rt_hit = rf_regwrite_q && (rf_rd_q == rt);
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_ent_valid[i] && (alu_ent_rd[i] == rs)) rs_hit = 1'b1;
      if (mem_ent_valid[i] && (mem_ent_rd[i] == rs)) rs_hit = 1'b1;
      if (alu_ent_valid[i] && (alu_ent_rd[i] == rt)) rt_hit = 1'b1;
      if (mem_ent_valid[i] && (mem_ent_rd[i] == rt)) rt_hit = 1'b1;
    end
    rs_pending = (rs != '0) && rs_hit;
    rt_pending = (rt != '0) && rt_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q   <= SRC_ALU;
      rf_rd_q        <= '0;
      rf_writedata_q <= '0;
      rf_regwrite_q  <= 1'b0;
    end else begin
      last_grant_q   <= last_grant_d;
      rf_rd_q        <= rf_rd_d;
      rf_writedata_q <= rf_writedata_d;
      rf_regwrite_q  <= rf_regwrite_d;
    end
  end

  assign rf_rd        = rf_rd_q;
  assign rf_writedata = rf_writedata_q;
  assign rf_regwrite  = rf_regwrite_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, rf_rd, rs, rt;
  logic [31:0] alu_data, mem_data, rf_writedata;
  logic        rf_regwrite, rs_pending, rt_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_rd(rf_rd), .rf_writedata(rf_writedata), .rf_regwrite(rf_regwrite),
    .rs(rs), .rt(rt), .rs_pending(rs_pending), .rt_pending(rt_pending)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    rst_n     = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    rs = '0; rt = '0;
    #3;
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%0h exp=0", rf_regwrite); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rf_rd got=%0h exp=0", rf_rd); end
    checks++; if (rf_writedata !== 32'd0) begin errors++; $display("FAIL reset_writedata got=%0h exp=0", rf_writedata); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got=%0h exp=1", alu_ready); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got=%0h exp=1", mem_ready); end
    #9;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'd5;
    tick();
    alu_valid = 1'b0;
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL single_early got=%0h exp=0", rf_regwrite); end
    tick();
    checks++; if (rf_regwrite !== 1'b1) begin errors++; $display("FAIL single_regwrite got=%0h exp=1", rf_regwrite); end
    checks++; if (rf_rd !== 5'd4) begin errors++; $display("FAIL single_rd got=%0h exp=4", rf_rd); end
    checks++; if (rf_writedata !== 32'd5) begin errors++; $display("FAIL single_data got=%0h exp=5", rf_writedata); end
    tick();
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL single_drop got=%0h exp=0", rf_regwrite); end
    checks++; if (rf_rd !== 5'd4 || rf_writedata !== 32'd5) begin errors++; $display("FAIL single_hold got=%0h/%0h exp=4/5", rf_rd, rf_writedata); end
  endtask

  task automatic test_pending;
    rs = 5'd7; rt = 5'd3;
    #1;
    checks++; if (rs_pending !== 1'b0) begin errors++; $display("FAIL pend_idle got=%0h exp=0", rs_pending); end
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    tick();
    alu_valid = 1'b0;
    checks++; if (rs_pending !== 1'b1) begin errors++; $display("FAIL pend_queued got=%0h exp=1", rs_pending); end
    checks++; if (rt_pending !== 1'b0) begin errors++; $display("FAIL pend_rt got=%0h exp=0", rt_pending); end
    tick();
    checks++; if (rs_pending !== 1'b1 || rf_regwrite !== 1'b1) begin errors++; $display("FAIL pend_write got=%0h/%0h exp=1/1", rs_pending, rf_regwrite); end
    tick();
    checks++; if (rs_pending !== 1'b0) begin errors++; $display("FAIL pend_clear got=%0h exp=0", rs_pending); end
    rs = '0; rt = '0;
  endtask

  task automatic test_rd_zero;
    rs = 5'd0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF;
    tick();
    mem_valid = 1'b0;
    checks++; if (rs_pending !== 1'b0) begin errors++; $display("FAIL rd0_pend got=%0h exp=0", rs_pending); end
    tick();
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL rd0_regwrite got=%0h exp=0", rf_regwrite); end
    checks++; if (rf_rd !== 5'd0 || rf_writedata !== 32'hFFFF) begin errors++; $display("FAIL rd0_consumed got=%0h/%0h exp=0/ffff", rf_rd, rf_writedata); end
    tick();
    checks++; if (rf_regwrite !== 1'b0 || mem_ready !== 1'b1) begin errors++; $display("FAIL rd0_after got=%0h/%0h exp=0/1", rf_regwrite, mem_ready); end
  endtask

  task automatic test_back_to_back;
    int na, nm, ea, em;
    logic a_acc, m_acc;
    logic [4:0] got[$];
    logic [4:0] exp_seq [8];
    exp_seq = '{5'd9, 5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12, 5'd4};
    do_reset();
    na = 1; nm = 9;
    for (int c = 0; c < 24; c++) begin
      alu_valid = (na <= 6);  alu_rd = 5'(na); alu_data = 32'(na + 100);
      mem_valid = (nm <= 14); mem_rd = 5'(nm); mem_data = 32'(nm + 100);
      a_acc = alu_valid && alu_ready;
      m_acc = mem_valid && mem_ready;
      tick();
      if (a_acc) na++;
      if (m_acc) nm++;
      if (c == 1) begin
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL b2b_alu_full_ready got=%0h exp=0", alu_ready); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_mem_ready got=%0h exp=1", mem_ready); end
      end
      if (rf_regwrite === 1'b1) begin
        got.push_back(rf_rd);
        checks++; if (rf_writedata !== 32'(rf_rd) + 32'd100) begin errors++; $display("FAIL b2b_data got=%0h exp=%0h", rf_writedata, 32'(rf_rd) + 32'd100); end
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++; if (got.size() != 12) begin errors++; $display("FAIL b2b_count got=%0d exp=12", got.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL b2b_order[%0d] got=none exp=%0d", i, exp_seq[i]); end
      else if (got[i] !== exp_seq[i]) begin errors++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, got[i], exp_seq[i]); end
    end
    ea = 1; em = 9;
    foreach (got[i]) begin
      checks++;
      if (got[i] < 5'd9) begin
        if (got[i] !== 5'(ea)) begin errors++; $display("FAIL b2b_alu_seq got=%0d exp=%0d", got[i], ea); end
        ea++;
      end else begin
        if (got[i] !== 5'(em)) begin errors++; $display("FAIL b2b_mem_seq got=%0d exp=%0d", got[i], em); end
        em++;
      end
    end
  endtask

  task automatic test_reset_mid;
    int writes;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(c + 1); alu_data = 32'(c);
      mem_valid = 1'b1; mem_rd = 5'(c + 9); mem_data = 32'(c);
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++; if (rf_regwrite !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%0h exp=1", rf_regwrite); end
    rs = 5'd11;
    rst_n = 1'b0;
    #1;
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL rstmid_regwrite got=%0h exp=0", rf_regwrite); end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%0h/%0h exp=1/1", alu_ready, mem_ready); end
    checks++; if (rs_pending !== 1'b0) begin errors++; $display("FAIL rstmid_pend got=%0h exp=0", rs_pending); end
    #2;
    rst_n = 1'b1;
    rs = '0;
    writes = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rf_regwrite !== 1'b0) writes++;
    end
    checks++; if (writes != 0) begin errors++; $display("FAIL rstmid_nowrite got=%0d exp=0", writes); end
  endtask

  task automatic test_full_pop;
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hAA;
    tick();
    mem_valid = 1'b0;
    alu_rd = 5'd3; alu_data = 32'h33;
    tick();
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0h exp=0", alu_ready); end
    checks++; if (rf_rd !== 5'd10 || rf_regwrite !== 1'b1) begin errors++; $display("FAIL full_memfirst got=%0h/%0h exp=a/1", rf_rd, rf_regwrite); end
    alu_rd = 5'd20; alu_data = 32'h2020;
    tick();
    alu_valid = 1'b0;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got=%0h exp=1", alu_ready); end
    checks++; if (rf_rd !== 5'd2) begin errors++; $display("FAIL full_pop1 got=%0h exp=2", rf_rd); end
    tick();
    checks++; if (rf_rd !== 5'd3 || rf_regwrite !== 1'b1) begin errors++; $display("FAIL full_pop2 got=%0h/%0h exp=3/1", rf_rd, rf_regwrite); end
    tick();
    checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL full_no_push got=%0h/%0h exp=0", rf_regwrite, rf_rd); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_pending();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    test_full_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
